// File: rtl/shift_4b_rx_if.sv
// Bundles the shift_4b_rx serial input, word output handshake and status outputs.
// Valid/ready: a word moves only on a rising clk edge where out_valid && out_ready are both high.
interface shift_4b_rx_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH);

   logic             start;
   logic             in_valid;
   logic             in_bit;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic [CW-1:0]    bit_count;
   logic             overflow;
   logic             buf_state_dbg;

   modport master (
      output start, in_valid, in_bit, out_ready,
      input  out_data, out_valid, bit_count, overflow, buf_state_dbg
   );

   modport slave (
      input  start, in_valid, in_bit, out_ready,
      output out_data, out_valid, bit_count, overflow, buf_state_dbg
   );
endinterface

// File: rtl/shift_4b_rx.sv
// Serial-to-parallel deserializer: collects WIDTH bits into a word and holds it
// in a one-entry output buffer drained by a valid/ready consumer.
module shift_4b_rx #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input logic          clk,
   input logic          rst,
   shift_4b_rx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   buf_state_t       state, state_next;
   logic [WIDTH-1:0] sr, sr_next, sr_base, word;
   logic [CW-1:0]    cnt, cnt_next, cnt_base;
   logic [WIDTH-1:0] data, data_next;
   logic             ovf, ovf_next;
   logic             complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         sr    <= '0;
         cnt   <= '0;
         data  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         sr    <= sr_next;
         cnt   <= cnt_next;
         data  <= data_next;
         ovf   <= ovf_next;
      end
   end

   // start resyncs the collector first, so a bit arriving with it is bit 0 of a fresh word.
   always_comb begin
      sr_base  = bus.start ? '0 : sr;
      cnt_base = bus.start ? '0 : cnt;
      if (MSB_FIRST != 0) word = {sr_base[WIDTH-2:0], bus.in_bit};
      else                word = {bus.in_bit, sr_base[WIDTH-1:1]};
      complete = bus.in_valid && (cnt_base == LAST);

      sr_next  = sr_base;
      cnt_next = cnt_base;
      if (bus.in_valid) begin
         if (complete) begin
            sr_next  = '0;
            cnt_next = '0;
         end else begin
            sr_next  = word;
            cnt_next = cnt_base + 1'b1;
         end
      end
   end

   // Output buffer: a word completing while the old one is consumed replaces it;
   // a word completing against a stalled consumer is dropped and flagged.
   always_comb begin
      state_next = state;
      data_next  = data;
      ovf_next   = ovf;
      unique case (state)
         EMPTY: begin
            if (complete) begin
               state_next = FULL;
               data_next  = word;
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               if (complete) data_next = word;
               else          state_next = EMPTY;
            end else if (complete) begin
               ovf_next = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   assign bus.out_data      = data;
   assign bus.out_valid     = (state == FULL);
   assign bus.bit_count     = cnt;
   assign bus.overflow      = ovf;
   assign bus.buf_state_dbg = state;
endmodule

// File: tb/tb_shift_4b_rx.sv
// Directed plus randomized bench for shift_4b_rx; one MSB-first and one LSB-first
// instance share the same stimulus and are compared against a queue-based model.
module tb_shift_4b_rx;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   shift_4b_rx_if #(.WIDTH(W)) bus0 ();
   shift_4b_rx_if #(.WIDTH(W)) bus1 ();

   assign bus0.start     = start;
   assign bus0.in_valid  = in_valid;
   assign bus0.in_bit    = in_bit;
   assign bus0.out_ready = out_ready;
   assign bus1.start     = start;
   assign bus1.in_valid  = in_valid;
   assign bus1.in_bit    = in_bit;
   assign bus1.out_ready = out_ready;

   shift_4b_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(bus0));
   shift_4b_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   // Reference model: received bits kept in arrival order, word built arithmetically.
   bit         m_bits[2][$];
   logic [W-1:0] m_data[2];
   logic       m_valid[2];
   logic       m_ovf[2];

   function automatic logic [W-1:0] compose(int k);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < m_bits[k].size(); i++) begin
         if (k == 0) w[W-1-i] = m_bits[k][i];
         else        w[i]     = m_bits[k][i];
      end
      return w;
   endfunction

   task automatic model_update(bit r, bit s, bit v, bit b, bit rdy);
      for (int k = 0; k < 2; k++) begin
         bit done;
         logic [W-1:0] w;
         done = 1'b0;
         w = '0;
         if (r) begin
            m_bits[k].delete();
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_ovf[k]   = 1'b0;
         end else begin
            if (s) m_bits[k].delete();
            if (v) begin
               m_bits[k].push_back(b);
               if (m_bits[k].size() == W) begin
                  w = compose(k);
                  done = 1'b1;
                  m_bits[k].delete();
               end
            end
            if (!m_valid[k]) begin
               if (done) begin
                  m_valid[k] = 1'b1;
                  m_data[k]  = w;
               end
            end else if (rdy) begin
               if (done) m_data[k] = w;
               else      m_valid[k] = 1'b0;
            end else if (done) begin
               m_ovf[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("msb_data",  32'(bus0.out_data),  32'(m_data[0]));
      chk("msb_valid", 32'(bus0.out_valid), 32'(m_valid[0]));
      chk("msb_cnt",   32'(bus0.bit_count), m_bits[0].size());
      chk("msb_ovf",   32'(bus0.overflow),  32'(m_ovf[0]));
      chk("lsb_data",  32'(bus1.out_data),  32'(m_data[1]));
      chk("lsb_valid", 32'(bus1.out_valid), 32'(m_valid[1]));
      chk("lsb_cnt",   32'(bus1.bit_count), m_bits[1].size());
      chk("lsb_ovf",   32'(bus1.overflow),  32'(m_ovf[1]));
   endtask

   // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
   task automatic step(bit r, bit s, bit v, bit b, bit rdy);
      rst = r; start = s; in_valid = v; in_bit = b; out_ready = rdy;
      @(posedge clk);
      model_update(r, s, v, b, rdy);
      #1;
      check_model();
   endtask

   task automatic send(logic [3:0] bits, bit rdy);
      for (int i = 3; i >= 0; i--) step(0, 0, 1, bits[i], rdy);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_data[k] = '0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
      end

      // Reset values
      step(1, 0, 0, 0, 1);
      chk("rst_valid", 32'(bus0.out_valid), 0);
      chk("rst_cnt",   32'(bus0.bit_count), 0);

      // Back-to-back bits 1,0,0,0; valid for exactly one cycle
      send(4'b1000, 1);
      chk("t1_data",  32'(bus0.out_data),  32'h8);
      chk("t1_valid", 32'(bus0.out_valid), 1);
      chk("t1_lsb",   32'(bus1.out_data),  32'h1);
      step(0, 0, 0, 0, 1);
      chk("t1_drop",  32'(bus0.out_valid), 0);
      chk("t1_ovf",   32'(bus0.overflow),  0);

      // Bits 1,1,0,1 with idle gaps
      step(0, 0, 1, 1, 1); chk("t2_cnt1", 32'(bus0.bit_count), 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 1); chk("t2_cnt2", 32'(bus0.bit_count), 2);
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1); chk("t2_cnt3", 32'(bus0.bit_count), 3);
      chk("t2_early", 32'(bus0.out_valid), 0);
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 1); chk("t2_cnt0", 32'(bus0.bit_count), 0);
      chk("t2_data", 32'(bus0.out_data), 32'hD);
      step(0, 0, 0, 0, 1);

      // Overflow with stalled consumer
      send(4'b1010, 0);
      send(4'b0110, 0);
      chk("t3_data", 32'(bus0.out_data), 32'hA);
      chk("t3_ovf",  32'(bus0.overflow), 1);
      step(0, 0, 0, 0, 1);
      chk("t3_valid", 32'(bus0.out_valid), 0);
      chk("t3_sticky", 32'(bus0.overflow), 1);

      // Replace on the handshake edge
      step(1, 0, 0, 0, 0);
      send(4'b0011, 0);
      step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      chk("t4_data",  32'(bus0.out_data),  32'hC);
      chk("t4_valid", 32'(bus0.out_valid), 1);
      chk("t4_ovf",   32'(bus0.overflow),  0);
      step(0, 0, 0, 0, 1);

      // start with a bit, then start alone
      step(0, 0, 1, 1, 1); step(0, 0, 1, 1, 1);
      step(0, 1, 1, 0, 1); chk("t5_cnt", 32'(bus0.bit_count), 1);
      step(0, 0, 1, 0, 1); step(0, 0, 1, 0, 1); step(0, 0, 1, 1, 1);
      chk("t5_data", 32'(bus0.out_data), 32'h1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 1); step(0, 0, 1, 1, 1);
      step(0, 1, 0, 0, 1); chk("t5_cnt0", 32'(bus0.bit_count), 0);
      step(0, 0, 1, 1, 1); step(0, 0, 1, 0, 1); step(0, 0, 1, 1, 1);
      chk("t5_nocomp", 32'(bus0.out_valid), 0);
      step(0, 0, 1, 0, 1);
      chk("t5_data2", 32'(bus0.out_data), 32'hA);

      // Reset mid-word with buffer full, then LSB-first word
      send(4'b0101, 0);
      step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0);
      chk("t6_data",  32'(bus0.out_data),  0);
      chk("t6_valid", 32'(bus0.out_valid), 0);
      chk("t6_cnt",   32'(bus0.bit_count), 0);
      send(4'b0001, 1);
      chk("t6_lsb", 32'(bus1.out_data), 32'h8);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
